// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap, MRET and FENCE.I sequencer
// Drives the CSR file through the trap entry/exit sequence and redirects fetch.
module trap_controller #(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trapped,
    input  logic [2:0]      trap_status,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] bad_addr,
    input  logic [XLEN-1:0] csr_read_data,
    input  logic            icache_flush_done,
    output logic            trap_stall,
    output logic            csr_write_enable,
    output logic [11:0]     csr_write_address,
    output logic [XLEN-1:0] csr_write_data,
    output logic [11:0]     csr_read_address,
    output logic            icache_flush,
    output logic            trap_redirect,
    output logic [XLEN-1:0] trap_target,
    output logic            mret_commit,
    output logic            flush_timeout
);

    localparam logic [2:0] TRAP_NONE       = 3'd0;
    localparam logic [2:0] TRAP_ECALL      = 3'd1;
    localparam logic [2:0] TRAP_EBREAK     = 3'd2;
    localparam logic [2:0] TRAP_MISALIGNED = 3'd3;
    localparam logic [2:0] TRAP_MRET       = 3'd4;
    localparam logic [2:0] TRAP_FENCEI     = 3'd5;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    // FLUSH is left in its FLUSH_TIMEOUT-th cycle when no done pulse arrives
    localparam logic [7:0] CNT_LAST = 8'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MEPC,
        S_WR_MCAUSE,
        S_WR_MTVAL,
        S_RD_MTVEC,
        S_RD_MEPC,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   bad_q, bad_d;
    logic [2:0]        status_q, status_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              trap_valid;

    // Codes above FENCEI are undefined and behave like NONE
    assign trap_valid = trapped && (trap_status != TRAP_NONE) && (trap_status <= TRAP_FENCEI);

    assign trap_stall    = reset & ((state_q != S_IDLE) | trap_valid);
    assign flush_timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            bad_q     <= '0;
            status_q  <= TRAP_NONE;
            target_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            bad_q     <= bad_d;
            status_q  <= status_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        bad_d             = bad_q;
        status_d          = status_q;
        target_d          = target_q;
        cnt_d             = cnt_q;
        timeout_d         = timeout_q;
        csr_write_enable  = 1'b0;
        csr_write_address = '0;
        csr_write_data    = '0;
        csr_read_address  = '0;
        icache_flush      = 1'b0;
        trap_redirect     = 1'b0;
        trap_target       = '0;
        mret_commit       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trap_valid) begin
                    pc_d     = pc;
                    bad_d    = bad_addr;
                    status_d = trap_status;
                    cnt_d    = '0;
                    case (trap_status)
                        TRAP_MRET:   state_d = S_RD_MEPC;
                        TRAP_FENCEI: begin
                            state_d  = S_FLUSH;
                            target_d = pc + XLEN'(4);
                        end
                        default:     state_d = S_WR_MEPC;
                    endcase
                end
            end
            S_WR_MEPC: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MEPC;
                csr_write_data    = pc_q;
                state_d           = S_WR_MCAUSE;
            end
            S_WR_MCAUSE: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MCAUSE;
                case (status_q)
                    TRAP_ECALL:  csr_write_data = XLEN'(11);
                    TRAP_EBREAK: csr_write_data = XLEN'(3);
                    default:     csr_write_data = '0;
                endcase
                state_d = S_WR_MTVAL;
            end
            S_WR_MTVAL: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MTVAL;
                case (status_q)
                    TRAP_MISALIGNED: csr_write_data = bad_q;
                    TRAP_EBREAK:     csr_write_data = pc_q;
                    default:         csr_write_data = '0;
                endcase
                state_d = S_RD_MTVEC;
            end
            S_RD_MTVEC: begin
                // Only direct mode is supported, so the mode bits are dropped
                csr_read_address = CSR_MTVEC;
                target_d         = csr_read_data & ~XLEN'(3);
                state_d          = S_REDIRECT;
            end
            S_RD_MEPC: begin
                csr_read_address = CSR_MEPC;
                target_d         = csr_read_data & ~XLEN'(3);
                state_d          = S_REDIRECT;
            end
            S_FLUSH: begin
                icache_flush = (cnt_q == 8'd0);
                cnt_d        = cnt_q + 8'd1;
                if (icache_flush_done) begin
                    state_d = S_REDIRECT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_REDIRECT;
                    timeout_d = 1'b1;
                end
            end
            S_REDIRECT: begin
                trap_redirect = 1'b1;
                trap_target   = target_q;
                mret_commit   = (status_q == TRAP_MRET);
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed-vector bench for trap_controller
module tb_trap_controller;

    localparam logic [2:0] T_NONE   = 3'd0;
    localparam logic [2:0] T_ECALL  = 3'd1;
    localparam logic [2:0] T_EBREAK = 3'd2;
    localparam logic [2:0] T_MIS    = 3'd3;
    localparam logic [2:0] T_MRET   = 3'd4;
    localparam logic [2:0] T_FENCEI = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trapped = 1'b0;
    logic [2:0]  trap_status = 3'd0;
    logic [31:0] pc = 32'h0;
    logic [31:0] bad_addr = 32'h0;
    logic [31:0] csr_read_data;
    logic        icache_flush_done = 1'b0;
    logic        trap_stall, csr_write_enable, icache_flush, trap_redirect, mret_commit, flush_timeout;
    logic [11:0] csr_write_address, csr_read_address;
    logic [31:0] csr_write_data, trap_target;

    logic [31:0] mtvec_v = 32'h8000_0003;
    logic [31:0] mepc_v  = 32'h0000_0104;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          vecs = 0;
    int          errs = 0;
    logic        exp_to = 1'b0;
    logic [93:0] obs;

    trap_controller #(.XLEN(32), .FLUSH_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .trapped(trapped), .trap_status(trap_status),
        .pc(pc), .bad_addr(bad_addr), .csr_read_data(csr_read_data),
        .icache_flush_done(icache_flush_done), .trap_stall(trap_stall),
        .csr_write_enable(csr_write_enable), .csr_write_address(csr_write_address),
        .csr_write_data(csr_write_data), .csr_read_address(csr_read_address),
        .icache_flush(icache_flush), .trap_redirect(trap_redirect),
        .trap_target(trap_target), .mret_commit(mret_commit),
        .flush_timeout(flush_timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        csr_read_data = 32'h0;
        if (csr_read_address == 12'h305) csr_read_data = mtvec_v;
        else if (csr_read_address == 12'h341) csr_read_data = mepc_v;
    end

    always @(posedge clk) begin
        if (csr_write_enable) wr_cnt <= wr_cnt + 1;
        if (trap_redirect) rd_cnt <= rd_cnt + 1;
    end

    assign obs = {trap_stall, csr_write_enable, csr_write_address, csr_write_data, csr_read_address,
                  icache_flush, trap_redirect, trap_target, mret_commit, flush_timeout};

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        vecs++;
        if (obs !== 94'h0) begin
            $display("FAIL reset_asserted: got %h expected %h", obs, 94'h0); errs++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vecs++;
        if (obs !== 94'h0) begin
            $display("FAIL reset_released: got %h expected %h", obs, 94'h0); errs++;
        end
    endtask

    task automatic test_exception(input logic [2:0] code, input logic [31:0] tpc,
                                  input logic [31:0] tbad, input logic spurious, input string name);
        logic        e_st, e_we, e_fl, e_rd, e_mr;
        logic [11:0] e_wa, e_ra;
        logic [31:0] e_wd, e_tg, cause, tval;
        logic [93:0] exp_v;
        int          w0;
        w0    = wr_cnt;
        cause = (code == T_ECALL) ? 32'd11 : (code == T_EBREAK) ? 32'd3 : 32'd0;
        tval  = (code == T_MIS) ? tbad : (code == T_EBREAK) ? tpc : 32'd0;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            trapped     = (c == 0) || (spurious && c == 2);
            trap_status = (c == 0) ? code : T_ECALL;
            pc          = (c == 0) ? tpc : 32'hDEAD_0000;
            bad_addr    = (c == 0) ? tbad : 32'hBEEF_0000;
            #1;
            e_st = (c <= 5); e_we = 1'b0; e_fl = 1'b0; e_rd = 1'b0; e_mr = 1'b0;
            e_wa = 12'h0; e_ra = 12'h0; e_wd = 32'h0; e_tg = 32'h0;
            case (c)
                1: begin e_we = 1'b1; e_wa = 12'h341; e_wd = tpc; end
                2: begin e_we = 1'b1; e_wa = 12'h342; e_wd = cause; end
                3: begin e_we = 1'b1; e_wa = 12'h343; e_wd = tval; end
                4: e_ra = 12'h305;
                5: begin e_rd = 1'b1; e_tg = mtvec_v & ~32'h3; end
                default: ;
            endcase
            exp_v = {e_st, e_we, e_wa, e_wd, e_ra, e_fl, e_rd, e_tg, e_mr, exp_to};
            vecs++;
            if (obs !== exp_v) begin
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp_v); errs++;
            end
        end
        trapped = 1'b0;
        vecs++;
        if (wr_cnt !== w0 + 3) begin
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_cnt - w0, 3); errs++;
        end
    endtask

    task automatic test_mret(input logic [31:0] mepc);
        logic [93:0] exp_v;
        int          w0;
        mepc_v = mepc;
        w0     = wr_cnt;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            trapped     = (c == 0);
            trap_status = T_MRET;
            pc          = 32'h0000_0500;
            #1;
            case (c)
                0:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                1:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h341, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                2:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b1, mepc & ~32'h3, 1'b1, exp_to};
                default: exp_v = {1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
            endcase
            vecs++;
            if (obs !== exp_v) begin
                $display("FAIL mret cycle %0d: got %h expected %h", c, obs, exp_v); errs++;
            end
        end
        vecs++;
        if (wr_cnt !== w0) begin
            $display("FAIL mret write_count: got %0d expected 0", wr_cnt - w0); errs++;
        end
    endtask

    task automatic test_fencei(input logic [31:0] tpc, input int done_at, input string name);
        logic [93:0] exp_v;
        int          nf, w0;
        nf = (done_at != 0) ? done_at : 255;
        w0 = wr_cnt;
        for (int c = 0; c <= nf + 2; c++) begin
            @(negedge clk);
            trapped           = (c == 0);
            trap_status       = T_FENCEI;
            pc                = (c == 0) ? tpc : 32'hDEAD_0000;
            icache_flush_done = (done_at != 0) && (c == done_at);
            #1;
            if (done_at == 0 && c == nf + 1) exp_to = 1'b1;
            exp_v = {(c <= nf + 1), 1'b0, 12'h0, 32'h0, 12'h0, (c == 1), (c == nf + 1),
                     (c == nf + 1) ? tpc + 32'd4 : 32'h0, 1'b0, exp_to};
            vecs++;
            if (obs !== exp_v) begin
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp_v); errs++;
            end
        end
        icache_flush_done = 1'b0;
        vecs++;
        if (wr_cnt !== w0) begin
            $display("FAIL %s write_count: got %0d expected 0", name, wr_cnt - w0); errs++;
        end
    endtask

    task automatic test_ignore();
        logic [93:0] exp_v;
        int          w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            trapped     = (c <= 1);
            trap_status = (c == 0) ? T_NONE : 3'd7;
            #1;
            exp_v = {1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
            vecs++;
            if (obs !== exp_v) begin
                $display("FAIL ignore cycle %0d: got %h expected %h", c, obs, exp_v); errs++;
            end
        end
        trapped = 1'b0;
        vecs++;
        if (wr_cnt !== w0 || rd_cnt !== r0) begin
            $display("FAIL ignore activity: got writes %0d redirects %0d expected 0 0",
                     wr_cnt - w0, rd_cnt - r0); errs++;
        end
    endtask

    task automatic test_back_to_back();
        logic [93:0] exp_v;
        mepc_v = 32'h0000_0703;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            trapped     = (c == 0) || (c == 6);
            trap_status = (c == 6) ? T_MRET : T_ECALL;
            pc          = 32'h0000_0600;
            #1;
            case (c)
                0, 6:    exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                1:       exp_v = {1'b1, 1'b1, 12'h341, 32'h600, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                2:       exp_v = {1'b1, 1'b1, 12'h342, 32'd11, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                3:       exp_v = {1'b1, 1'b1, 12'h343, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                4:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h305, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                5:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, exp_to};
                7:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h341, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
                8:       exp_v = {1'b1, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b1, 32'h700, 1'b1, exp_to};
                default: exp_v = {1'b0, 1'b0, 12'h0, 32'h0, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
            endcase
            vecs++;
            if (obs !== exp_v) begin
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs, exp_v); errs++;
            end
        end
        trapped = 1'b0;
    endtask

    task automatic test_reset_midseq();
        logic [93:0] exp_v;
        int          w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            trapped     = (c == 0);
            trap_status = T_ECALL;
            pc          = 32'h0000_0900;
        end
        #1;
        exp_v = {1'b1, 1'b1, 12'h342, 32'd11, 12'h0, 1'b0, 1'b0, 32'h0, 1'b0, exp_to};
        vecs++;
        if (obs !== exp_v) begin
            $display("FAIL midseq_wr_mcause: got %h expected %h", obs, exp_v); errs++;
        end
        #1 reset = 1'b0;
        exp_to = 1'b0;
        #1;
        vecs++;
        if (obs !== 94'h0) begin
            $display("FAIL midseq_reset_outputs: got %h expected %h", obs, 94'h0); errs++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        vecs++;
        if (wr_cnt !== w0 + 1 || rd_cnt !== r0 || obs !== 94'h0) begin
            $display("FAIL midseq_abandon: got writes %0d redirects %0d obs %h expected 1 0 0",
                     wr_cnt - w0, rd_cnt - r0, obs); errs++;
        end
        test_exception(T_ECALL, 32'h0000_0A00, 32'h0, 1'b0, "ecall_after_reset");
    endtask

    initial begin
        test_reset();
        test_exception(T_ECALL, 32'h0000_0100, 32'h0, 1'b0, "ecall");
        test_exception(T_MIS, 32'h0000_0200, 32'h0000_0206, 1'b1, "misaligned");
        test_exception(T_EBREAK, 32'h0000_0300, 32'h0000_0777, 1'b0, "ebreak");
        test_mret(32'h0000_0104);
        test_fencei(32'h0000_0400, 3, "fencei_done");
        test_fencei(32'hFFFF_FFFC, 1, "fencei_wrap");
        test_ignore();
        test_back_to_back();
        test_fencei(32'h0000_0480, 0, "fencei_timeout");
        test_reset_midseq();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
